ex_alu_muldiv: RTL and testbench
================================

Name: ex_alu_muldiv

Overview:
- Execute stage of the single-clock MIPS core, directly downstream of instruction decode.
- Consumes the instruction word, the two register read values and the 32-bit extended immediate.
- Produces the single-cycle ALU result, plus the branch-compare flag for beq/bne.
- Owns the HI/LO registers and an iterative 32-cycle multiply/divide unit; asserts Stall to freeze PC and register write while a HI/LO consumer waits on a busy unit.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported and verified.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- Ins  in  32  current instruction. Op = Ins[31:26], shamt = Ins[10:6], funct = Ins[5:0].
- Rdata1  in  32  rs value.
- Rdata2  in  32  rt value.
- Ed32  in  32  extended immediate, already sign- or zero-extended by decode.
- Result  out  32  ALU / mfhi / mflo result; also the lw/sw address.
- Zero  out  1  1 when Rdata1 == Rdata2.
- Stall  out  1  1 means the instruction cannot complete this cycle; hold PC and suppress register write.
- MdBusy  out  1  multiply/divide iteration in progress.

Behaviour:
- Reset values (RST high at an edge): state IDLE, HI = LO = 0, iteration counter = 0, MdBusy = 0.
- While RST is high, Stall is forced to 0.
- Result and Zero are combinational and are not registered.

ALU, combinational, Op 000000 by funct:
- add/addu: rs+rt.
- sub/subu: rs-rt.
- and, or, xor, nor.
- slt: signed compare, result 1/0.
- sltu: unsigned compare, result 1/0.
- sll/srl/sra: rt shifted by shamt.
- sllv/srlv/srav: rt shifted by rs[4:0].
- jr: Result = rs.
- No overflow trap: add/sub behave as addu/subu.

ALU, I-type, operand B = Ed32:
- addi/addiu: rs+Ed32.
- slti/sltiu: compare against Ed32 (signed / unsigned).
- andi/ori/xori: logical op with Ed32.
- lui: Ed32[15:0] concatenated with 16'b0.
- lw (100011) / sw (101011): rs+Ed32.
- jal: Result don't-care.
- Any other opcode: Result = 0.

Mult/div ops (funct): mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mflo 010010, mthi 010001, mtlo 010011.

State machine IDLE / BUSY:
- IDLE + mult/multu/div/divu: latch operands and signs at the edge, counter = 0, go to BUSY. Stall = 0 in the issue cycle (non-blocking issue).
- BUSY: one radix-2 iteration per edge. Multiply is shift-add on magnitudes; divide is restoring on magnitudes.
- Final edge (counter == 31): write HI/LO, go to IDLE. Operation occupies exactly 32 BUSY cycles.
- MdBusy = 1 exactly in BUSY.
- Stall = 1 when in BUSY and Ins is any of the eight mult/div ops; otherwise 0.
- A stalled op re-evaluates each cycle and proceeds in the first IDLE cycle.
- mfhi/mflo in IDLE: Result = HI / LO in the same cycle.
- mthi/mtlo in IDLE: HI / LO <= rs at the edge.
- Signed mult: 64-bit product of two's-complement operands; HI = upper 32 bits, LO = lower 32 bits.
- Signed div: LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
- Divide by zero (div or divu): LO = 0xFFFFFFFF, HI = rs. No exception.
- div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- RST during BUSY: operation abandoned, reset values apply, next cycle IDLE.
- Non-mult/div instructions in BUSY execute normally without stalling.

Test Plan:
- multu 0xFFFFFFFF x 0x00000002, then mfhi/mflo → Stall high 32 cycles after issue, then HI = 0x00000001, LO = 0xFFFFFFFE.
- mult -3 x 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. div -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- divu 100 / 0 → LO = 0xFFFFFFFF, HI = 100. div 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- mult issued, then 5 addu instructions, then mflo → addu results correct with Stall 0; mflo stalls until exactly 32 cycles after the issue edge.
- RST pulsed at BUSY cycle 10 → MdBusy = 0 next cycle, HI = LO = 0; a following mfhi returns 0 with no stall.
- ALU spot checks:
  - slt 0xFFFFFFFF, 1 → 1; sltu 0xFFFFFFFF, 1 → 0.
  - sra 0x80000000 by 4 → 0xF8000000.
  - lui Ed32 = 0x1234 → 0x12340000.
  - beq with equal operands → Zero = 1.

Source files
------------

// File: rtl/ex_alu_muldiv.sv
// Execute stage: single-cycle ALU, branch compare, HI/LO registers
// and a 32-cycle iterative multiply/divide unit with stall control.
module ex_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Ins,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic [WIDTH-1:0] Ed32,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Stall,
  output logic             MdBusy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  state_t      state, state_nxt;
  logic [5:0]  op, fn;
  logic [4:0]  sh;
  logic        is_r, md_start, md_any;
  logic        mf_hi, mf_lo, mt_hi, mt_lo;
  logic [31:0] hi, lo;
  logic [4:0]  cnt;
  logic [31:0] wk_hi, wk_lo, opnd, rs_raw;
  logic        is_div, neg_q, neg_r, dz;
  logic        unused_bits;

  assign op = Ins[31:26];
  assign fn = Ins[5:0];
  assign sh = Ins[10:6];
  assign unused_bits = ^Ins[25:11];

  assign is_r  = (op == 6'b000000);
  assign mf_hi = is_r && fn == F_MFHI;
  assign mf_lo = is_r && fn == F_MFLO;
  assign mt_hi = is_r && fn == F_MTHI;
  assign mt_lo = is_r && fn == F_MTLO;
  assign md_start = is_r && (fn == F_MULT || fn == F_MULTU ||
                             fn == F_DIV  || fn == F_DIVU);
  assign md_any = md_start || mf_hi || mf_lo || mt_hi || mt_lo;

  assign Zero = (Rdata1 == Rdata2);

  // ALU result: R-type by funct, I-type by opcode with Ed32 as operand B
  always_comb begin
    Result = '0;
    if (is_r) begin
      case (fn)
        6'b100000, 6'b100001: Result = Rdata1 + Rdata2;
        6'b100010, 6'b100011: Result = Rdata1 - Rdata2;
        6'b100100: Result = Rdata1 & Rdata2;
        6'b100101: Result = Rdata1 | Rdata2;
        6'b100110: Result = Rdata1 ^ Rdata2;
        6'b100111: Result = ~(Rdata1 | Rdata2);
        6'b101010: Result = {31'b0, $signed(Rdata1) < $signed(Rdata2)};
        6'b101011: Result = {31'b0, Rdata1 < Rdata2};
        6'b000000: Result = Rdata2 << sh;
        6'b000010: Result = Rdata2 >> sh;
        6'b000011: Result = $unsigned($signed(Rdata2) >>> sh);
        6'b000100: Result = Rdata2 << Rdata1[4:0];
        6'b000110: Result = Rdata2 >> Rdata1[4:0];
        6'b000111: Result = $unsigned($signed(Rdata2) >>> Rdata1[4:0]);
        6'b001000: Result = Rdata1;
        F_MFHI:    Result = hi;
        F_MFLO:    Result = lo;
        default:   Result = '0;
      endcase
    end else begin
      case (op)
        6'b001000, 6'b001001: Result = Rdata1 + Ed32;
        6'b001010: Result = {31'b0, $signed(Rdata1) < $signed(Ed32)};
        6'b001011: Result = {31'b0, Rdata1 < Ed32};
        6'b001100: Result = Rdata1 & Ed32;
        6'b001101: Result = Rdata1 | Ed32;
        6'b001110: Result = Rdata1 ^ Ed32;
        6'b001111: Result = {Ed32[15:0], 16'b0};
        6'b100011, 6'b101011: Result = Rdata1 + Ed32;
        default:   Result = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state, busy flag and stall
  always_comb begin
    state_nxt = state;
    MdBusy    = 1'b0;
    Stall     = 1'b0;
    case (state)
      IDLE: if (md_start) state_nxt = BUSY;
      BUSY: begin
        MdBusy = 1'b1;
        Stall  = md_any && !RST;
        if (cnt == 5'd31) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic        sgn, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_sh, div_df;
  logic [31:0] nxt_hi, nxt_lo;
  logic [63:0] prod, prod_s;

  assign sgn   = (fn == F_MULT) || (fn == F_DIV);
  assign sa    = sgn && Rdata1[31];
  assign sb    = sgn && Rdata2[31];
  assign a_mag = sa ? -Rdata1 : Rdata1;
  assign b_mag = sb ? -Rdata2 : Rdata2;

  // One radix-2 step: shift-add multiply or restoring divide
  always_comb begin
    mul_sum = {1'b0, wk_hi} + {1'b0, (wk_lo[0] ? opnd : 32'b0)};
    div_sh  = {wk_hi, wk_lo[31]};
    div_df  = div_sh - {1'b0, opnd};
    if (is_div) begin
      nxt_hi = div_df[32] ? div_sh[31:0] : div_df[31:0];
      nxt_lo = {wk_lo[30:0], ~div_df[32]};
    end else begin
      nxt_hi = mul_sum[32:1];
      nxt_lo = {mul_sum[0], wk_lo[31:1]};
    end
    prod   = {nxt_hi, nxt_lo};
    prod_s = neg_q ? -prod : prod;
  end

  // HI/LO registers and iteration datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      wk_hi  <= '0;
      wk_lo  <= '0;
      opnd   <= '0;
      rs_raw <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else if (state == IDLE) begin
      if (md_start) begin
        is_div <= fn[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dz     <= (Rdata2 == 32'b0);
        rs_raw <= Rdata1;
        cnt    <= '0;
        wk_hi  <= '0;
        wk_lo  <= fn[1] ? a_mag : b_mag;
        opnd   <= fn[1] ? b_mag : a_mag;
      end else if (mt_hi) begin
        hi <= Rdata1;
      end else if (mt_lo) begin
        lo <= Rdata1;
      end
    end else begin
      wk_hi <= nxt_hi;
      wk_lo <= nxt_lo;
      cnt   <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        if (!is_div) begin
          hi <= prod_s[63:32];
          lo <= prod_s[31:0];
        end else if (dz) begin
          hi <= rs_raw;
          lo <= 32'hFFFF_FFFF;
        end else begin
          hi <= neg_r ? -nxt_hi : nxt_hi;
          lo <= neg_q ? -nxt_lo : nxt_lo;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_muldiv.sv
// Directed bench for ex_alu_muldiv: ALU spot checks,
// mult/div results, stall timing and reset during a busy op.
module tb_ex_alu_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins, Rdata1, Rdata2, Ed32;
  logic [31:0] Result;
  logic        Zero, Stall, MdBusy;

  int total = 0;
  int bad   = 0;
  int n;

  ex_alu_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Ins(Ins),
    .Rdata1(Rdata1), .Rdata2(Rdata2), .Ed32(Ed32),
    .Result(Result), .Zero(Zero),
    .Stall(Stall), .MdBusy(MdBusy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rt(input logic [5:0] f,
                                     input logic [4:0] s);
    return {6'b0, 15'b0, s, f};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] o);
    return {o, 26'b0};
  endfunction

  localparam logic [31:0] MFHI  = {26'b0, 6'b010000};
  localparam logic [31:0] MTHI  = {26'b0, 6'b010001};
  localparam logic [31:0] MFLO  = {26'b0, 6'b010010};
  localparam logic [31:0] MULT  = {26'b0, 6'b011000};
  localparam logic [31:0] MULTU = {26'b0, 6'b011001};
  localparam logic [31:0] DIV   = {26'b0, 6'b011010};
  localparam logic [31:0] DIVU  = {26'b0, 6'b011011};
  localparam logic [31:0] ADDU  = {26'b0, 6'b100001};

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic md_run(input string tag, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    Ins = ins; Rdata1 = a; Rdata2 = b;
    #1;
    chk({tag, "_issue_stall"}, {31'b0, Stall}, 32'd0);
    tick;
    chk({tag, "_busy"}, {31'b0, MdBusy}, 32'd1);
    Ins = MFHI;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    chk({tag, "_stall_cycles"}, n, 32'd32);
    chk({tag, "_hi"}, Result, ehi);
    Ins = MFLO;
    #1;
    chk({tag, "_lo"}, Result, elo);
  endtask

  initial begin
    RST = 1'b1; Ins = '0; Rdata1 = '0; Rdata2 = '0; Ed32 = '0;
    tick;
    tick;
    Ins = MULT;
    #1;
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    RST = 1'b0;
    Ins = MFHI;
    #1;
    chk("rst_busy", {31'b0, MdBusy}, 32'd0);
    chk("rst_hi", Result, 32'd0);
    chk("rst_hi_stall", {31'b0, Stall}, 32'd0);
    Ins = MFLO;
    #1;
    chk("rst_lo", Result, 32'd0);

    Ins = rt(6'b101010, 5'd0); Rdata1 = 32'hFFFF_FFFF; Rdata2 = 32'd1;
    #1;
    chk("slt", Result, 32'd1);
    Ins = rt(6'b101011, 5'd0);
    #1;
    chk("sltu", Result, 32'd0);
    Ins = rt(6'b000011, 5'd4); Rdata2 = 32'h8000_0000;
    #1;
    chk("sra", Result, 32'hF800_0000);
    Ins = rt(6'b000010, 5'd4);
    #1;
    chk("srl", Result, 32'h0800_0000);
    Ins = rt(6'b000100, 5'd0); Rdata1 = 32'd3; Rdata2 = 32'h0000_0011;
    #1;
    chk("sllv", Result, 32'h0000_0088);
    Ins = rt(6'b100010, 5'd0); Rdata1 = 32'd5; Rdata2 = 32'd7;
    #1;
    chk("sub", Result, 32'hFFFF_FFFE);
    Ins = rt(6'b100111, 5'd0); Rdata1 = 32'hF0F0_0000; Rdata2 = 32'h0000_0F0F;
    #1;
    chk("nor", Result, 32'h0F0F_F0F0);
    Ins = it(6'b001111); Ed32 = 32'h0000_1234;
    #1;
    chk("lui", Result, 32'h1234_0000);
    Ins = it(6'b100011); Rdata1 = 32'h1000; Ed32 = 32'hFFFF_FFFC;
    #1;
    chk("lw_addr", Result, 32'h0000_0FFC);
    Ins = it(6'b001010); Rdata1 = 32'hFFFF_FFFE; Ed32 = 32'hFFFF_FFFF;
    #1;
    chk("slti", Result, 32'd1);
    Ins = it(6'b111111);
    #1;
    chk("bad_op", Result, 32'd0);
    Ins = it(6'b000100); Rdata1 = 32'h55; Rdata2 = 32'h55;
    #1;
    chk("beq_eq", {31'b0, Zero}, 32'd1);
    Rdata2 = 32'h56;
    #1;
    chk("beq_ne", {31'b0, Zero}, 32'd0);

    md_run("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
    md_run("mult", MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    md_run("div", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    md_run("divu0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    md_run("divmin", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    md_run("divu", DIVU, 32'd1000, 32'd7, 32'd6, 32'd142);

    Ins = MULT; Rdata1 = 32'd7; Rdata2 = 32'd6;
    #1;
    tick;
    for (int i = 0; i < 5; i++) begin
      Ins = ADDU; Rdata1 = 32'd10 * i; Rdata2 = 32'd3;
      #1;
      chk("addu_busy", Result, 32'd10 * i + 32'd3);
      chk("addu_stall", {31'b0, Stall}, 32'd0);
      tick;
    end
    Ins = MFLO;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      n++;
      tick;
    end
    chk("mflo_wait", n, 32'd27);
    chk("mflo_val", Result, 32'd42);

    Ins = MTHI; Rdata1 = 32'hCAFE_F00D;
    #1;
    tick;
    Ins = MFHI;
    #1;
    chk("mthi", Result, 32'hCAFE_F00D);

    Ins = MULT; Rdata1 = 32'd9; Rdata2 = 32'd9;
    #1;
    tick;
    Ins = ADDU;
    for (int i = 0; i < 9; i++) tick;
    Ins = MFHI; RST = 1'b1;
    #1;
    chk("rst_busy_stall", {31'b0, Stall}, 32'd0);
    tick;
    RST = 1'b0;
    #1;
    chk("rst_abort_busy", {31'b0, MdBusy}, 32'd0);
    chk("rst_abort_stall", {31'b0, Stall}, 32'd0);
    chk("rst_abort_hi", Result, 32'd0);
    Ins = MFLO;
    #1;
    chk("rst_abort_lo", Result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
